// File: rtl/fifo_arb_pkg.sv
// Shared constants for the input-FIFO to output-FIFO round-robin arbiter.
package fifo_arb_pkg;

  localparam int unsigned NUM_Q_DEF    = 4;
  localparam int unsigned DATA_W_DEF   = 6;
  localparam int unsigned DEST_MSB_DEF = 5;
  localparam int unsigned DEST_W       = $clog2(NUM_Q_DEF);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACTIVE = 2'd1;
  localparam logic [1:0] ST_PAUSED = 2'd2;

endpackage

// File: rtl/rr_grant.sv
// Combinational grant picker: round-robin after 'last', or fixed lowest-index
// priority when ARB_STRICT_PRIO_EN is defined.
module rr_grant
  import fifo_arb_pkg::*;
#(
  parameter int unsigned N     = NUM_Q_DEF,
  parameter int unsigned IDX_W = DEST_W
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last,
  output logic [N-1:0]     gnt_c,
  output logic [IDX_W-1:0] idx_c
);

`ifdef ARB_STRICT_PRIO_EN
  logic unused_last;
  assign unused_last = ^last;

  always_comb begin
    gnt_c = '0;
    idx_c = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (req[i] && (gnt_c == '0)) begin
        gnt_c = N'(1) << i;
        idx_c = IDX_W'(i);
      end
    end
  end
`else
  logic [IDX_W-1:0] cand;

  // Search starts one past the last winner; IDX_W-bit wrap gives modulo N.
  always_comb begin
    gnt_c = '0;
    idx_c = '0;
    cand  = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      cand = last + IDX_W'(k);
      if (req[cand] && (gnt_c == '0)) begin
        gnt_c = N'(1) << cand;
        idx_c = cand;
      end
    end
  end
`endif

endmodule

// File: rtl/fifo_rr_arbiter.sv
// Pops the input FIFOs one word per cycle and routes each word to the output
// FIFO named by its destination field. ARB_STRICT_PRIO_EN selects fixed priority.
module fifo_rr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NUM_Q    = NUM_Q_DEF,
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned DEST_MSB = DEST_MSB_DEF
) (
  input  logic                      clk,
  input  logic                      RESET,
  input  logic [NUM_Q-1:0]          in_empty,
  input  logic [NUM_Q*DATA_W-1:0]   in_data,
  input  logic [NUM_Q-1:0]          in_valid,
  input  logic [NUM_Q-1:0]          out_pause,
  output logic [NUM_Q-1:0]          in_rd,
  output logic [NUM_Q-1:0]          out_wr,
  output logic [DATA_W-1:0]         out_data,
  output logic                      active,
  output logic                      err_arb
);

  localparam int unsigned SEL_W = $clog2(NUM_Q);

  logic [1:0]        state_q,     state_d;
  logic [NUM_Q-1:0]  in_rd_q,     in_rd_d;
  logic [NUM_Q-1:0]  rd_prev_q,   rd_prev_d;
  logic [NUM_Q-1:0]  empty_dec_q, empty_dec_d;
  logic [NUM_Q-1:0]  out_wr_q,    out_wr_d;
  logic [DATA_W-1:0] out_data_q,  out_data_d;
  logic              active_q,    active_d;
  logic              err_q,       err_d;

  logic [SEL_W-1:0]  last_c;
  logic [NUM_Q-1:0]  gnt_c;
  logic [SEL_W-1:0]  gnt_idx_c;
  logic              pause_any_c;
  logic              all_empty_c;
  logic              pop_c;
  logic              val_any_c;
  logic              val_onehot_c;
  logic [DATA_W-1:0] word_c;
  logic [SEL_W-1:0]  dest_c;

  rr_grant #(
    .N     (NUM_Q),
    .IDX_W (SEL_W)
  ) u_grant (
    .req   (~in_empty),
    .last  (last_c),
    .gnt_c (gnt_c),
    .idx_c (gnt_idx_c)
  );

`ifdef ARB_STRICT_PRIO_EN
  logic unused_idx;
  assign unused_idx = ^gnt_idx_c;
  assign last_c     = SEL_W'(NUM_Q - 1);
`else
  logic [SEL_W-1:0] last_q, last_d;

  always_comb begin
    last_d = last_q;
    if (pop_c) last_d = gnt_idx_c;
  end

  always_ff @(posedge clk) begin
    if (RESET) last_q <= SEL_W'(NUM_Q - 1);
    else       last_q <= last_d;
  end

  assign last_c = last_q;
`endif

  // Control FSM, pop issue and the single in-flight output stage.
  always_comb begin
    pause_any_c  = |out_pause;
    all_empty_c  = &in_empty;
    state_d      = state_q;
    in_rd_d      = '0;
    rd_prev_d    = in_rd_q;
    empty_dec_d  = in_empty;
    out_wr_d     = '0;
    out_data_d   = out_data_q;
    err_d        = err_q;
    word_c       = '0;
    dest_c       = '0;

    case (state_q)
      ST_IDLE: begin
        if (pause_any_c)       state_d = ST_PAUSED;
        else if (!all_empty_c) state_d = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (pause_any_c)      state_d = ST_PAUSED;
        else if (all_empty_c) state_d = ST_IDLE;
      end
      ST_PAUSED: begin
        if (!pause_any_c) state_d = all_empty_c ? ST_IDLE : ST_ACTIVE;
      end
      default: state_d = ST_IDLE;
    endcase

    // A same-cycle pause blocks the pop even before the state leaves ACTIVE.
    pop_c = (state_q == ST_ACTIVE) && !pause_any_c && !all_empty_c;
    if (pop_c) in_rd_d = gnt_c;

    val_any_c    = |in_valid;
    val_onehot_c = val_any_c && ((in_valid & (in_valid - NUM_Q'(1))) == '0);
    for (int unsigned i = 0; i < NUM_Q; i++) begin
      if (in_valid[i]) word_c = in_data[i*DATA_W +: DATA_W];
    end
    dest_c = word_c[DEST_MSB -: SEL_W];

    if (val_onehot_c) begin
      out_wr_d   = NUM_Q'(1) << dest_c;
      out_data_d = word_c;
    end

    if ((val_any_c && !val_onehot_c) ||
        ((in_valid & ~rd_prev_q) != '0) ||
        ((in_rd_q & empty_dec_q) != '0)) begin
      err_d = 1'b1;
    end

    active_d = (state_d == ST_ACTIVE);
  end

  always_ff @(posedge clk) begin
    if (RESET) begin
      state_q     <= ST_IDLE;
      in_rd_q     <= '0;
      rd_prev_q   <= '0;
      empty_dec_q <= '0;
      out_wr_q    <= '0;
      out_data_q  <= '0;
      active_q    <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_rd_q     <= in_rd_d;
      rd_prev_q   <= rd_prev_d;
      empty_dec_q <= empty_dec_d;
      out_wr_q    <= out_wr_d;
      out_data_q  <= out_data_d;
      active_q    <= active_d;
      err_q       <= err_d;
    end
  end

  assign in_rd    = in_rd_q;
  assign out_wr   = out_wr_q;
  assign out_data = out_data_q;
  assign active   = active_q;
  assign err_arb  = err_q;

endmodule

// File: tb/tb_fifo_rr_arbiter.sv
// Directed scoreboard bench for fifo_rr_arbiter; input FIFOs are modelled with
// queues that answer in_rd with in_valid one cycle later.
module tb_fifo_rr_arbiter;

  logic        clk = 1'b0;
  logic        RESET;
  logic [3:0]  in_empty;
  logic [23:0] in_data;
  logic [3:0]  in_valid;
  logic [3:0]  out_pause;
  logic [3:0]  in_rd;
  logic [3:0]  out_wr;
  logic [5:0]  out_data;
  logic        active;
  logic        err_arb;

  typedef struct packed {
    logic [3:0] wr;
    logic [5:0] data;
  } exp_t;

  exp_t       exp_q[$];
  logic [5:0] fq[4][$];
  logic [3:0] prio_rd[4];
  int         checks;
  int         errors;

  fifo_rr_arbiter dut (
    .clk       (clk),
    .RESET     (RESET),
    .in_empty  (in_empty),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .out_pause (out_pause),
    .in_rd     (in_rd),
    .out_wr    (out_wr),
    .out_data  (out_data),
    .active    (active),
    .err_arb   (err_arb)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h", name, act, req);
    end
  endtask

  task automatic update_empty();
    for (int i = 0; i < 4; i++) in_empty[i] = (fq[i].size() == 0);
  endtask

  task automatic load(input int q, input logic [5:0] w);
    fq[q].push_back(w);
    update_empty();
  endtask

  task automatic expect_w(input logic [3:0] wr, input logic [5:0] data);
    exp_t e;
    e.wr   = wr;
    e.data = data;
    exp_q.push_back(e);
  endtask

  // One clock; the FIFO model answers the in_rd seen during the cycle.
  task automatic tick();
    logic [3:0] rd_s;
    rd_s = in_rd;
    @(posedge clk);
    #1;
    in_valid = '0;
    for (int i = 0; i < 4; i++) begin
      if (rd_s[i] && (fq[i].size() > 0)) begin
        in_data[i*6 +: 6] = fq[i].pop_front();
        in_valid[i]       = 1'b1;
      end
    end
    update_empty();
  endtask

  task automatic wait_rd(input int maxc);
    int n;
    n = 0;
    while ((in_rd == 4'b0) && (n < maxc)) begin
      tick();
      n++;
    end
    if (in_rd == 4'b0) begin
      checks++;
      errors++;
      $display("FAIL wait_rd: actual in_rd=0 after %0d cycles, required a pop", maxc);
    end
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    tick();
    tick();
    RESET = 1'b0;
  endtask

  // Monitor: every push must match the next expected word, in order.
  always @(negedge clk) begin
    exp_t e;
    if ((RESET === 1'b0) && (out_wr !== 4'b0)) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_push: actual out_wr=%b out_data=%h, required no push", out_wr, out_data);
      end else begin
        e = exp_q.pop_front();
        chk("sb_out_wr", 32'(out_wr), 32'(e.wr));
        chk("sb_out_data", 32'(out_data), 32'(e.data));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

`ifdef ARB_STRICT_PRIO_EN
  initial prio_rd = '{4'b0001, 4'b0001, 4'b0001, 4'b0001};
`else
  initial prio_rd = '{4'b0001, 4'b1000, 4'b0001, 4'b1000};
`endif

  initial begin
    checks    = 0;
    errors    = 0;
    RESET     = 1'b1;
    in_empty  = '1;
    in_valid  = '0;
    in_data   = '0;
    out_pause = '0;
    repeat (3) tick();

    // Reset values
    chk("rst_in_rd", 32'(in_rd), 0);
    chk("rst_out_wr", 32'(out_wr), 0);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_active", 32'(active), 0);
    chk("rst_err", 32'(err_arb), 0);

    // First pop after reset goes to FIFO 0
    load(0, 6'h05);
    load(2, 6'h13);
    expect_w(4'b0001, 6'h05);
    expect_w(4'b0010, 6'h13);
    tick();
    RESET = 1'b0;
    wait_rd(10);
    chk("first_pop", 32'(in_rd), 32'h1);
    repeat (8) tick();
    chk("t1_idle", 32'(active), 0);

    // Reset clears the held out_data
    RESET = 1'b1;
    tick();
    chk("rst_mid_out_data", 32'(out_data), 0);
    tick();
    RESET = 1'b0;

    // Round-robin over four FIFOs with two words each
    load(0, 6'h00); load(0, 6'h31);
    load(1, 6'h1A); load(1, 6'h22);
    load(2, 6'h2B); load(2, 6'h0C);
    load(3, 6'h3D); load(3, 6'h15);
    expect_w(4'b0001, 6'h00);
    expect_w(4'b0010, 6'h1A);
    expect_w(4'b0100, 6'h2B);
    expect_w(4'b1000, 6'h3D);
    expect_w(4'b1000, 6'h31);
    expect_w(4'b0100, 6'h22);
    expect_w(4'b0001, 6'h0C);
    expect_w(4'b0010, 6'h15);
    wait_rd(10);
    for (int k = 0; k < 8; k++) begin
      chk("rr_order", 32'(in_rd), 32'(4'b0001 << (k % 4)));
      chk("rr_active", 32'(active), 1);
      tick();
    end
    repeat (6) tick();
    chk("rr_idle", 32'(active), 0);
    chk("rr_drained", 32'(exp_q.size()), 0);

    // Routing and latency: in_rd -> out_wr in two cycles
    do_reset();
    load(1, 6'h2A);
    expect_w(4'b0100, 6'h2A);
    wait_rd(10);
    chk("route_rd", 32'(in_rd), 32'h2);
    tick();
    chk("route_no_early_wr", 32'(out_wr), 0);
    tick();
    chk("route_wr", 32'(out_wr), 32'h4);
    chk("route_data", 32'(out_data), 32'h2A);
    repeat (4) tick();

    // Back-pressure mid-stream
    do_reset();
    load(0, 6'h01); load(0, 6'h12); load(0, 6'h23); load(0, 6'h34);
    load(1, 6'h05); load(1, 6'h16); load(1, 6'h27); load(1, 6'h38);
    expect_w(4'b0001, 6'h01);
    expect_w(4'b0001, 6'h05);
    expect_w(4'b0010, 6'h12);
    expect_w(4'b0010, 6'h16);
    expect_w(4'b0100, 6'h23);
    expect_w(4'b0100, 6'h27);
    expect_w(4'b1000, 6'h34);
    expect_w(4'b1000, 6'h38);
    wait_rd(10);
    tick();
    tick();
    out_pause = 4'b1000;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("pause_no_rd", 32'(in_rd), 0);
      chk("pause_inactive", 32'(active), 0);
    end
    out_pause = 4'b0000;
    repeat (20) tick();
    chk("pause_idle", 32'(active), 0);
    chk("pause_drained", 32'(exp_q.size()), 0);

    // Non-one-hot in_valid sets the sticky error and is dropped
    do_reset();
    chk("err_clear", 32'(err_arb), 0);
    in_data  = 24'h3C_2A_15;
    in_valid = 4'b0011;
    tick();
    chk("err_set", 32'(err_arb), 1);
    chk("err_no_wr", 32'(out_wr), 0);
    repeat (3) tick();
    chk("err_sticky", 32'(err_arb), 1);
    RESET = 1'b1;
    tick();
    chk("err_reset", 32'(err_arb), 0);
    RESET = 1'b0;
    tick();

    // FIFOs 0 and 3 both backlogged
    do_reset();
    load(0, 6'h0A); load(0, 6'h1B); load(0, 6'h2C);
    load(3, 6'h3E); load(3, 6'h0F); load(3, 6'h11);
`ifdef ARB_STRICT_PRIO_EN
    expect_w(4'b0001, 6'h0A);
    expect_w(4'b0010, 6'h1B);
    expect_w(4'b0100, 6'h2C);
    expect_w(4'b1000, 6'h3E);
    expect_w(4'b0001, 6'h0F);
    expect_w(4'b0010, 6'h11);
`else
    expect_w(4'b0001, 6'h0A);
    expect_w(4'b1000, 6'h3E);
    expect_w(4'b0010, 6'h1B);
    expect_w(4'b0001, 6'h0F);
    expect_w(4'b0100, 6'h2C);
    expect_w(4'b0010, 6'h11);
`endif
    wait_rd(10);
    for (int k = 0; k < 4; k++) begin
      chk("prio_order", 32'(in_rd), 32'(prio_rd[k]));
      tick();
    end
    repeat (12) tick();
    chk("prio_drained", 32'(exp_q.size()), 0);
    chk("final_err", 32'(err_arb), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
